// File: rtl/cpu_mul_pkg.sv
// Shared types and constants for the multiply-cell scheduler.
// Provides the per-requester state enum, the in-flight tag struct and the index-width helper.
// No logic; every scheduler file imports it.
package cpu_mul_pkg;

  localparam int MUL_W     = 32;
  localparam int MAX_REQ   = 8;
  // Tag ids are sized for the largest supported requester count.
  localparam int TAG_W_MAX = $clog2(MAX_REQ);

  // Requester index width, at least one bit even for a single requester.
  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] id;
  } mul_tag_t;

endpackage

// File: rtl/cpu_mul_rr_arbiter.sv
// Round-robin grant generator: first eligible requester at or after rr_ptr, wrapping.
// Latency: purely combinational. Backpressure: none; the caller owns the pointer update.
// Ports: eligible (in, N), rr_ptr (in, IDX_W), grant (out, one-hot N), grant_idx (out), any_grant (out).
module cpu_mul_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  // Pass 1 searches [rr_ptr, N-1]; pass 2 only matters when pass 1 found
  // nothing, so its first hit is the wrapped-around winner in [0, rr_ptr).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_grant && eligible[i] && (i >= int'(rr_ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
        any_grant = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any_grant && eligible[i]) begin
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_mul_sched.sv
// Round-robin scheduler sharing one 32x32->32 multiply cell among NUM_REQ requesters.
// Latency: accept at edge E -> rsp_valid after edge E+MUL_LATENCY+1 (2 clocks at default).
// Backpressure: one op outstanding per requester; a requester in DONE is not accepted until rsp handshake.
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_src1/req_src2 per requester;
//        rsp_valid/rsp_ready/rsp_result per requester; mul_src1/mul_src2 to cell, mul_result from cell; busy.
module cpu_mul_sched
  import cpu_mul_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MUL_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [MUL_W*NUM_REQ-1:0] req_src1,
  input  logic [MUL_W*NUM_REQ-1:0] req_src2,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [MUL_W*NUM_REQ-1:0] rsp_result,
  output logic [MUL_W-1:0]         mul_src1,
  output logic [MUL_W-1:0]         mul_src2,
  input  logic [MUL_W-1:0]         mul_result,
  output logic                     busy
);

  localparam int IDX_W = tag_width(NUM_REQ);

  mul_state_t           state     [NUM_REQ];
  mul_state_t           state_nxt [NUM_REQ];
  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 any_grant;
  logic [MUL_W-1:0]     sel_src1;
  logic [MUL_W-1:0]     sel_src2;
  logic                 busy_nxt;
  // Stage 0 travels with the issue register, stage MUL_LATENCY with the cell output.
  mul_tag_t             tag_pipe  [MUL_LATENCY+1];
  logic [MUL_W-1:0]     result_q  [NUM_REQ];
  logic                 exit_vld;
  logic [TAG_W_MAX-1:0] exit_id;

  assign exit_vld = tag_pipe[MUL_LATENCY].valid;
  assign exit_id  = tag_pipe[MUL_LATENCY].id;

  // Gating with reset keeps req_ready low while reset is held, since the
  // asynchronously cleared FSMs would otherwise look eligible.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (state[i] == IDLE) && !reset;
    end
  end

  cpu_mul_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel_src1 = '0;
    sel_src2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_src1 = req_src1[i*MUL_W +: MUL_W];
        sel_src2 = req_src2[i*MUL_W +: MUL_W];
      end
    end
  end

  // Per-requester FSM next state. A DONE requester releases only on its
  // response handshake, so a same-cycle new request is not seen as eligible.
  always_comb begin
    busy_nxt = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        IDLE:    if (grant[i]) state_nxt[i] = BUSY;
        BUSY:    if (exit_vld && (int'(exit_id) == i)) state_nxt[i] = DONE;
        DONE:    if (rsp_ready[i]) state_nxt[i] = IDLE;
        default: state_nxt[i] = IDLE;
      endcase
      if (state_nxt[i] != IDLE) busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state[i]    <= IDLE;
        result_q[i] <= '0;
      end
      for (int s = 0; s <= MUL_LATENCY; s++) begin
        tag_pipe[s] <= '0;
      end
      rr_ptr   <= '0;
      mul_src1 <= '0;
      mul_src2 <= '0;
      busy     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state[i] <= state_nxt[i];
        if (exit_vld && (int'(exit_id) == i)) result_q[i] <= mul_result;
      end
      tag_pipe[0].valid <= any_grant;
      tag_pipe[0].id    <= TAG_W_MAX'(grant_idx);
      for (int s = 1; s <= MUL_LATENCY; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
      // Operands hold between grants; only the tag valid marks a bubble.
      if (any_grant) begin
        mul_src1 <= sel_src1;
        mul_src2 <= sel_src2;
        if (int'(grant_idx) == NUM_REQ - 1) rr_ptr <= '0;
        else                                 rr_ptr <= grant_idx + 1'b1;
      end
      busy <= busy_nxt;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    assign rsp_valid[g]                  = (state[g] == DONE);
    assign rsp_result[g*MUL_W +: MUL_W] = result_q[g];
  end

endmodule

// File: tb/tb_cpu_mul_sched.sv
module tb_cpu_mul_sched;

  localparam int N = 2;
  localparam int L = 1;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W*N-1:0] req_src1, req_src2, rsp_result;
  logic [W-1:0]   mul_src1, mul_src2, mul_result;
  logic           busy;
  logic           cell_rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_mul_sched #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .mul_src1   (mul_src1),
    .mul_src2   (mul_src2),
    .mul_result (mul_result),
    .busy       (busy)
  );

  // Behavioural multiply cell: L registered stages, active-low reset.
  logic [W-1:0] cell_pipe [L];
  assign cell_rst_n = ~reset;
  assign mul_result = cell_pipe[L-1];
  always @(posedge clk or negedge cell_rst_n) begin
    if (!cell_rst_n) begin
      for (int i = 0; i < L; i++) cell_pipe[i] <= '0;
    end else begin
      cell_pipe[0] <= mul_src1 * mul_src2;
      for (int i = 1; i < L; i++) cell_pipe[i] <= cell_pipe[i-1];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: each accepted op is scheduled to become visible
  // L+2 intervals after the interval in which it was granted.
  int           m_cyc = 0;
  bit           m_out  [N];
  int           m_done [N];
  logic [W-1:0] m_prod [N];
  logic [W-1:0] m_last [N];
  logic [W-1:0] m_s1, m_s2;
  int           m_rr, m_g, m_idx;
  logic [N-1:0]   e_rdy, e_rv;
  logic [W*N-1:0] e_res;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_out[i]  = 1'b0;
        m_last[i] = '0;
      end
      m_rr = 0; m_s1 = '0; m_s2 = '0;
      check("rst_req_ready", req_ready, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_busy", busy, 0);
      check("rst_mul_src1", mul_src1, 0);
      check("rst_rsp_result", rsp_result, 0);
    end else begin
      m_g = -1;
      for (int off = 0; off < N; off++) begin
        m_idx = (m_rr + off) % N;
        if (m_g < 0 && req_valid[m_idx] && !m_out[m_idx]) m_g = m_idx;
      end
      e_rdy = '0;
      if (m_g >= 0) e_rdy[m_g] = 1'b1;
      for (int i = 0; i < N; i++) begin
        e_rv[i] = m_out[i] && (m_cyc >= m_done[i]);
        e_res[i*W +: W] = m_last[i];
      end
      check("model_req_ready", req_ready, e_rdy);
      check("model_rsp_valid", rsp_valid, e_rv);
      check("model_rsp_result", rsp_result, e_res);
      check("model_mul_src1", mul_src1, m_s1);
      check("model_mul_src2", mul_src2, m_s2);
      check("model_busy", busy, 64'(|e_rv || m_out.or() != 0));
      if (m_g >= 0) begin
        m_out[m_g]  = 1'b1;
        m_done[m_g] = m_cyc + L + 2;
        m_s1 = req_src1[m_g*W +: W];
        m_s2 = req_src2[m_g*W +: W];
        m_prod[m_g] = m_s1 * m_s2;
        m_rr = (m_g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (e_rv[i] && rsp_ready[i]) m_out[i] = 1'b0;
      for (int i = 0; i < N; i++)
        if (m_out[i] && (m_cyc + 1 == m_done[i])) m_last[i] = m_prod[i];
    end
    m_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    req_src1[r*W +: W] = a;
    req_src2[r*W +: W] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_rsp(input int r);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid[r]) begin ok = 1'b1; break; end
      tick();
    end
    check($sformatf("wait_rsp%0d", r), ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int           cnt0, cnt1, cnt_bp;
  logic [N-1:0] gseq [3];
  logic [N-1:0] nxt_valid;

  initial begin
    reset = 1'b1; req_valid = '0; rsp_ready = '0; req_src1 = '0; req_src2 = '0;
    tick(); tick();
    check("reset_busy", busy, 0);
    reset = 1'b0;

    // Single op on requester 0.
    set_op(0, 32'h0001_0003, 32'h0002_0005);
    req_valid = 2'b01;
    @(negedge clk);
    check("single_accept", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check("single_issue_src1", mul_src1, 32'h0001_0003);
    tick();
    check("single_rsp_early", rsp_valid, 2'b00);
    tick();
    check("single_rsp_valid", rsp_valid, 2'b01);
    check("single_result", rsp_result[31:0], 32'h000B_000F);
    check("single_busy", busy, 1);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    check("single_released", rsp_valid, 2'b00);
    check("single_idle_busy", busy, 0);

    // Wraparound products.
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_op(1, 32'h8000_0000, 32'h0000_0002);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      nxt_valid = req_valid & ~req_ready;
      tick();
      req_valid = nxt_valid;
    end
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid == 2'b11) break;
      tick();
    end
    check("wrap_both_valid", rsp_valid, 2'b11);
    check("wrap_ffff_sq", rsp_result[31:0], 32'h0000_0001);
    check("wrap_8000x2", rsp_result[63:32], 32'h0000_0000);
    rsp_ready = 2'b11;
    tick();
    rsp_ready = '0;

    // Contention from a fresh reset: rr_ptr=0, both requesters always valid.
    do_reset();
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 24; k++) begin
      set_op(0, 32'h1000_0001 + 32'(k) * 32'h0101, 32'h0000_0003 + 32'(k));
      set_op(1, 32'h2000_0007 + 32'(k) * 32'h0011, 32'h0000_0100 + 32'(k));
      @(negedge clk);
      if (k < 3) gseq[k] = req_ready;
      if (req_ready[0]) cnt0++;
      if (req_ready[1]) cnt1++;
      tick();
    end
    check("cont_grant0", gseq[0], 2'b01);
    check("cont_grant1", gseq[1], 2'b10);
    check("cont_gap", gseq[2], 2'b00);
    check("cont_count0", cnt0, 6);
    check("cont_count1", cnt1, 6);
    req_valid = '0;
    repeat (4) tick();

    // Backpressure on requester 1.
    set_op(0, 32'd3, 32'd5);
    set_op(1, 32'h0000_1234, 32'h0000_0100);
    rsp_ready = 2'b01;
    req_valid = 2'b11;
    wait_rsp(1);
    cnt_bp = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_result1_hold", rsp_result[63:32], 32'h0012_3400);
      check("bp_valid1_hold", rsp_valid[1], 1);
      check("bp_ready1_low", req_ready[1], 0);
      if (req_ready[0]) cnt_bp++;
      tick();
    end
    check("bp_req0_served", cnt_bp >= 2, 1);
    rsp_ready = 2'b11;
    req_valid = '0;
    repeat (4) tick();

    // Response handshake and new request in the same cycle.
    rsp_ready = '0;
    set_op(0, 32'd7, 32'd9);
    req_valid = 2'b01;
    @(negedge clk);
    check("sc_first_accept", req_ready, 2'b01);
    tick();
    req_valid = '0;
    wait_rsp(0);
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    @(negedge clk);
    check("sc_no_accept_done", req_ready[0], 0);
    tick();
    @(negedge clk);
    check("sc_accept_next", req_ready[0], 1);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Reset while both requesters are BUSY.
    rsp_ready = '0;
    set_op(0, 32'd11, 32'd13);
    set_op(1, 32'd17, 32'd19);
    req_valid = 2'b11;
    tick(); tick();
    check("rst_mid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("async_rsp_valid", rsp_valid, 2'b00);
    check("async_req_ready", req_ready, 2'b00);
    check("async_busy", busy, 0);
    check("async_mul_src1", mul_src1, 0);
    check("async_mul_src2", mul_src2, 0);
    check("async_rsp_result", rsp_result, 0);
    tick();
    reset = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_no_stale", rsp_valid, 2'b00);
      tick();
    end
    set_op(1, 32'd7, 32'd6);
    req_valid = 2'b10;
    @(negedge clk);
    check("post_rst_accept", req_ready, 2'b10);
    tick();
    req_valid = '0;
    tick(); tick();
    check("post_rst_rsp_valid", rsp_valid, 2'b10);
    check("post_rst_result", rsp_result[63:32], 32'd42);
    rsp_ready = 2'b11;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
